mult_seq: RTL and testbench
===========================

# mult_seq

Multi-cycle radix-2 shift-add multiplier for the MIPS datapath, executing MULT/MULTU into the HI/LO register pair. It is the companion to the sequential divider: same start/busy/done handshake and the same HI/LO result convention. It is driven by the execute-stage controller, which stalls while Busy is high.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH bits split into HI/LO.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- Start  in  1  request pulse; sampled only in IDLE.
- Signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with Start.
- A  in  WIDTH  multiplicand; sampled with Start.
- B  in  WIDTH  multiplier; sampled with Start.
- Busy  out  1  high in CALC and FIX.
- Done  out  1  one-cycle pulse in DONE; HI/LO valid from this cycle.
- HI  out  WIDTH  upper product half; held until next result.
- LO  out  WIDTH  lower product half; held until next result.

## Operation
- States: IDLE, CALC, FIX, DONE. Reset: state IDLE, Busy 0, Done 0, HI 0, LO 0, counter 0, internal registers 0.
- IDLE: Start=1 at an edge latches magnitudes |A|, |B| (Signed=1 and MSB set -> two's negate; otherwise raw), sign flag = Signed & (A[MSB]^B[MSB]), accumulator 0, counter 0; go to CALC. Start=0: stay.
- Negation of -2^(WIDTH-1) yields 2^(WIDTH-1) as unsigned magnitude; no special case.
- CALC, per edge: if multiplier LSB=1, add multiplicand to accumulator upper half (WIDTH+1-bit sum, carry kept); shift {carry, accumulator, multiplier} right by one; counter+1. After the WIDTH-th iteration go to FIX.
- FIX: if sign flag, product = two's negate of 2*WIDTH-bit product; load HI/LO; go to DONE.
- DONE: Done=1 for exactly one cycle; next edge to IDLE unconditionally.
- Start outside IDLE is ignored (no queuing, no restart). Start in DONE cycle ignored.
- HI/LO change only on the FIX->DONE edge or reset.
- RST asserted mid-operation: immediate return to reset values; in-flight result discarded.

## Timing
- Edge 0 samples Start; Busy high from edge 0 through edge WIDTH+1.
- Edges 1..WIDTH: CALC iterations. Edge WIDTH+1: FIX loads HI/LO, enters DONE.
- Done high for one cycle after edge WIDTH+1 (WIDTH=32: after edge 33); IDLE after edge WIDTH+2.
- Earliest accepted back-to-back Start: sampled at edge WIDTH+3 (first IDLE edge).
- Busy and Done never high together; all outputs registered, no combinational path from inputs.

## Structure
- Shared package: state encoding (IDLE, CALC, FIX, DONE), default WIDTH, counter width as $clog2(WIDTH+1); shared with the divider.
- Sub-module: twos_negate (parameterized width, conditional negate with enable), instantiated for A, B (WIDTH) and product (2*WIDTH).
- Top: FSM, counter, accumulator/multiplier shift register, WIDTH+1 adder.

## Test plan
- MULTU A=3, B=5 -> HI=0x00000000, LO=0x0000000F; Done exactly one cycle after edge 33, Busy high edges 0..33.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 (carry into top accumulator bit exercised).
- MULT A=0xFFFFFFFF (-1), B=1 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF; MULT A=-7, B=-6 -> HI=0, LO=0x0000002A.
- MULT A=B=0x80000000 -> HI=0x40000000, LO=0x00000000; MULTU same operands -> HI=0x40000000, LO=0.
- Start with A=9,B=9 pulsed at edge 10 of a running 2*3 job -> ignored; result HI=0, LO=6; next job accepted only after Done.
- RST asserted at edge 15 of a job -> Busy, Done, HI, LO all 0 immediately; subsequent MULTU 4*4 -> LO=16 with normal latency.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// rtl/mult_seq_pkg.sv - shared state encoding and sizing for the sequential multiply/divide units
package mult_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/mult_seq_if.sv
// rtl/mult_seq_if.sv - start/busy/done handshake and HI/LO result bundle
interface mult_seq_if #(
    parameter int WIDTH = mult_seq_pkg::DEFAULT_WIDTH
);
    logic             Start;
    logic             Signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, Signed, A, B,
        input  Busy, Done, HI, LO
    );

    modport slave (
        input  Start, Signed, A, B,
        output Busy, Done, HI, LO
    );
endinterface

// File: rtl/mult_seq_twos_negate.sv
// rtl/mult_seq_twos_negate.sv - conditional two's-complement negation
module twos_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] data_i,
    input  logic         en_i,
    output logic [W-1:0] data_o
);

    // The most negative value negates to itself, which read as unsigned is its magnitude.
    assign data_o = en_i ? (~data_i + W'(1)) : data_i;

endmodule

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - radix-2 shift-add multiplier for MULT/MULTU into HI/LO
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mult_seq_if.slave    bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_fixed;

    twos_negate #(.W(WIDTH)) u_neg_a (
        .data_i (bus.A),
        .en_i   (bus.Signed & bus.A[WIDTH-1]),
        .data_o (a_mag)
    );

    twos_negate #(.W(WIDTH)) u_neg_b (
        .data_i (bus.B),
        .en_i   (bus.Signed & bus.B[WIDTH-1]),
        .data_o (b_mag)
    );

    twos_negate #(.W(2*WIDTH)) u_neg_prod (
        .data_i ({acc_q, mplier_q}),
        .en_i   (neg_q),
        .data_o (prod_fixed)
    );

    // Carry out of the partial-product add is kept and shifted into the accumulator MSB.
    assign sum = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

    // State register and datapath flops, cleared asynchronously so a reset discards any job.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state, shift-add iteration and registered Busy/Done derived from the next state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    neg_d    = bus.Signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d    = sum[WIDTH:1];
                mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                hi_d    = prod_fixed[2*WIDTH-1:WIDTH];
                lo_d    = prod_fixed[WIDTH-1:0];
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
        done_d = (state_d == ST_DONE);
    end

    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - scoreboard testbench for mult_seq
module tb_mult_seq;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2*W-1:0] exp_q[$];

    mult_seq_if #(.WIDTH(W)) bus ();

    mult_seq #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ea, eb;
        ea = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // Runs one job starting at the next edge; poke_edge > 0 pulses a stray Start(9*9) into that edge.
    task automatic run_job(input string tag, input bit sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int poke_edge);
        logic [2*W-1:0] exp_p;
        logic [2*W-1:0] got;
        int busy_err;
        busy_err = 0;
        @(negedge clk);
        bus.Start  = 1'b1;
        bus.Signed = sgn;
        bus.A      = a;
        bus.B      = b;
        exp_q.push_back(model(sgn, a, b));
        @(posedge clk);
        #1;
        check({tag, " busy@e0"}, {63'd0, bus.Busy}, 64'd1);
        bus.Start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        for (int k = 1; k <= 34; k++) begin
            if (k == poke_edge) begin
                bus.Start  = 1'b1;
                bus.Signed = 1'b0;
                bus.A      = 32'd9;
                bus.B      = 32'd9;
            end else begin
                bus.Start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (k <= 32) begin
                if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) busy_err++;
            end else if (k == 33) begin
                check({tag, " busy_calc"}, 64'(busy_err), 64'd0);
                check({tag, " done@e33"}, {62'd0, bus.Done, bus.Busy}, 64'd2);
                exp_p = exp_q.pop_front();
                got   = {bus.HI, bus.LO};
                check({tag, " result"}, got, exp_p);
            end else begin
                check({tag, " idle@e34"}, {62'd0, bus.Done, bus.Busy}, 64'd0);
                check({tag, " hold@e34"}, {bus.HI, bus.LO}, exp_p);
            end
        end
        bus.Start = 1'b0;
    endtask

    initial begin
        bus.Start  = 1'b0;
        bus.Signed = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        #12;
        check("reset_outputs", {bus.HI, bus.LO}, 64'd0);
        check("reset_flags", {62'd0, bus.Done, bus.Busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_job("multu_3x5", 1'b0, 32'd3, 32'd5, 0);
        check("multu_3x5_const", {bus.HI, bus.LO}, 64'h0000_0000_0000_000F);
        run_job("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("multu_max_const", {bus.HI, bus.LO}, 64'hFFFF_FFFE_0000_0001);
        run_job("mult_m1x1", 1'b1, 32'hFFFF_FFFF, 32'd1, 0);
        check("mult_m1x1_const", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFF);
        run_job("mult_m7xm6", 1'b1, -32'sd7, -32'sd6, 0);
        check("mult_m7xm6_const", {bus.HI, bus.LO}, 64'h0000_0000_0000_002A);
        run_job("mult_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 0);
        check("mult_min_const", {bus.HI, bus.LO}, 64'h4000_0000_0000_0000);
        run_job("multu_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
        run_job("mult_mixed", 1'b1, 32'h8000_0000, 32'd3, 0);

        run_job("poke_e10", 1'b0, 32'd2, 32'd3, 10);
        check("poke_e10_const", {bus.HI, bus.LO}, 64'd6);
        run_job("poke_done", 1'b0, 32'd7, 32'd11, 34);

        for (int i = 0; i < 6; i++) begin
            run_job($sformatf("rand%0d", i), 1'(i & 1), $urandom, $urandom, 0);
        end

        @(negedge clk);
        bus.Start  = 1'b1;
        bus.Signed = 1'b0;
        bus.A      = 32'd12345;
        bus.B      = 32'd678;
        exp_q.push_back(model(1'b0, 32'd12345, 32'd678));
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        for (int k = 1; k < 15; k++) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_flags", {62'd0, bus.Done, bus.Busy}, 64'd0);
        check("rst_mid_hilo", {bus.HI, bus.LO}, 64'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        run_job("after_rst_4x4", 1'b0, 32'd4, 32'd4, 0);
        check("after_rst_const", {bus.HI, bus.LO}, 64'd16);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
